edge_relaxer: RTL and testbench

// Relaxation stage of the Dijkstra datapath; sits directly downstream of EdgeCache. Given the newly

---
 rtl/edge_relaxer.sv | 187 ++++++++++++++++++
 tb/tb_edge_relaxer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_relaxer.sv
// Relaxation stage of the Dijkstra datapath: walks one adjacency row of the settled node
// through the EdgeCache query port and lowers dist[v]/prev[v] in the external distance table.
module edge_relaxer #(
    parameter int unsigned INDEX_WIDTH = 8,
    parameter int unsigned VALUE_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [INDEX_WIDTH-1:0] current_node,
    input  logic [VALUE_WIDTH-1:0] current_dist,
    input  logic [INDEX_WIDTH-1:0] number_of_nodes,
    output logic                   busy,
    output logic                   done,
    output logic [INDEX_WIDTH-1:0] relax_count,
    output logic                   query_enable,
    output logic [INDEX_WIDTH-1:0] from_node,
    output logic [INDEX_WIDTH-1:0] to_node,
    input  logic                   edge_ready,
    input  logic [VALUE_WIDTH-1:0] edge_value,
    output logic [INDEX_WIDTH-1:0] dist_rd_addr,
    input  logic [VALUE_WIDTH-1:0] dist_rd_data,
    input  logic                   visited_rd_data,
    output logic                   dist_wr_en,
    output logic [INDEX_WIDTH-1:0] dist_wr_addr,
    output logic [VALUE_WIDTH-1:0] dist_wr_data,
    output logic [INDEX_WIDTH-1:0] prev_wr_data
);

    // Column counter carries one extra bit so the last column of a full-size row cannot wrap.
    localparam int unsigned CW = INDEX_WIDTH + 1;
    localparam logic [VALUE_WIDTH-1:0] INF = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_WAIT,
        S_READ,
        S_CMP,
        S_WRITE,
        S_NEXT,
        S_FINISH
    } state_t;

    state_t                 state, state_d;
    logic [VALUE_WIDTH-1:0] du_q, du_d;
    logic [INDEX_WIDTH-1:0] n_q, n_d;
    logic [CW-1:0]          v_q, v_d;
    logic [VALUE_WIDTH-1:0] w_q, w_d;

    logic                   busy_d, done_d, query_enable_d, dist_wr_en_d;
    logic [INDEX_WIDTH-1:0] relax_count_d, from_node_d, to_node_d, dist_rd_addr_d;
    logic [INDEX_WIDTH-1:0] dist_wr_addr_d, prev_wr_data_d;
    logic [VALUE_WIDTH-1:0] dist_wr_data_d;

    logic [VALUE_WIDTH:0]   sum;
    logic                   relax_c;
    logic [CW-1:0]          last_v;
    logic [CW-1:0]          v_inc;

    // Candidate distance kept one bit wider so a carry out can never look like a shorter path.
    assign sum     = {1'b0, du_q} + {1'b0, w_q};
    assign relax_c = (w_q != '0) && (v_q[INDEX_WIDTH-1:0] != from_node) && !visited_rd_data
                  && (du_q != INF) && (sum < {1'b0, INF}) && (sum < {1'b0, dist_rd_data});
    assign last_v  = {1'b0, n_q} - CW'(1);
    assign v_inc   = v_q + CW'(1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            du_q         <= '0;
            n_q          <= '0;
            v_q          <= '0;
            w_q          <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            relax_count  <= '0;
            query_enable <= 1'b0;
            from_node    <= '0;
            to_node      <= '0;
            dist_rd_addr <= '0;
            dist_wr_en   <= 1'b0;
            dist_wr_addr <= '0;
            dist_wr_data <= '0;
            prev_wr_data <= '0;
        end else begin
            state        <= state_d;
            du_q         <= du_d;
            n_q          <= n_d;
            v_q          <= v_d;
            w_q          <= w_d;
            busy         <= busy_d;
            done         <= done_d;
            relax_count  <= relax_count_d;
            query_enable <= query_enable_d;
            from_node    <= from_node_d;
            to_node      <= to_node_d;
            dist_rd_addr <= dist_rd_addr_d;
            dist_wr_en   <= dist_wr_en_d;
            dist_wr_addr <= dist_wr_addr_d;
            dist_wr_data <= dist_wr_data_d;
            prev_wr_data <= prev_wr_data_d;
        end
    end

    always_comb begin
        state_d        = state;
        du_d           = du_q;
        n_d            = n_q;
        v_d            = v_q;
        w_d            = w_q;
        busy_d         = busy;
        done_d         = 1'b0;
        relax_count_d  = relax_count;
        query_enable_d = query_enable;
        from_node_d    = from_node;
        to_node_d      = to_node;
        dist_rd_addr_d = dist_rd_addr;
        dist_wr_en_d   = 1'b0;
        dist_wr_addr_d = dist_wr_addr;
        dist_wr_data_d = dist_wr_data;
        prev_wr_data_d = prev_wr_data;

        case (state)
            S_IDLE: begin
                if (start) begin
                    from_node_d   = current_node;
                    du_d          = current_dist;
                    n_d           = number_of_nodes;
                    v_d           = '0;
                    to_node_d     = '0;
                    relax_count_d = '0;
                    if (number_of_nodes == '0) begin
                        done_d  = 1'b1;
                        state_d = S_FINISH;
                    end else begin
                        query_enable_d = 1'b1;
                        busy_d         = 1'b1;
                        state_d        = S_SETTLE;
                    end
                end
            end
            // EdgeCache ready still reflects the previous column here.
            S_SETTLE: state_d = S_WAIT;
            S_WAIT: begin
                if (edge_ready) begin
                    w_d            = edge_value;
                    dist_rd_addr_d = v_q[INDEX_WIDTH-1:0];
                    state_d        = S_READ;
                end
            end
            S_READ: state_d = S_CMP;
            S_CMP: begin
                if (relax_c) begin
                    dist_wr_en_d   = 1'b1;
                    dist_wr_addr_d = v_q[INDEX_WIDTH-1:0];
                    dist_wr_data_d = sum[VALUE_WIDTH-1:0];
                    prev_wr_data_d = from_node;
                    relax_count_d  = relax_count + INDEX_WIDTH'(1);
                    state_d        = S_WRITE;
                end else begin
                    state_d = S_NEXT;
                end
            end
            S_WRITE: state_d = S_NEXT;
            S_NEXT: begin
                if (v_q == last_v) begin
                    query_enable_d = 1'b0;
                    busy_d         = 1'b0;
                    done_d         = 1'b1;
                    state_d        = S_FINISH;
                end else begin
                    v_d       = v_inc;
                    to_node_d = v_inc[INDEX_WIDTH-1:0];
                    state_d   = S_SETTLE;
                end
            end
            S_FINISH: begin
                query_enable_d = 1'b0;
                busy_d         = 1'b0;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_edge_relaxer.sv
// Scoreboard bench for edge_relaxer: EdgeCache and distance-RAM models, expected writes
// are queued from a reference model at start and compared against observed write strobes.
module tb_edge_relaxer;

    typedef logic [31:0] wr_t;   // {addr[7:0], data[15:0], prev[7:0]}

    logic        clock, reset, start;
    logic [7:0]  current_node, number_of_nodes, relax_count, from_node, to_node;
    logic [15:0] current_dist, edge_value, dist_rd_data, dist_wr_data;
    logic        busy, done, query_enable, edge_ready, visited_rd_data, dist_wr_en;
    logic [7:0]  dist_rd_addr, dist_wr_addr, prev_wr_data;

    logic [15:0] row_w    [256];
    logic [15:0] dist_mem [256];
    logic        vis_mem  [256];

    int          edge_delay;
    logic        toggle_mode;
    logic [8:0]  last_to;
    int          cnt;
    logic        mismatch;

    wr_t         exp_q[$];
    wr_t         obs_q[$];
    int          n_cmp, n_fail;

    edge_relaxer dut (
        .clock(clock), .reset(reset), .start(start),
        .current_node(current_node), .current_dist(current_dist),
        .number_of_nodes(number_of_nodes), .busy(busy), .done(done),
        .relax_count(relax_count), .query_enable(query_enable),
        .from_node(from_node), .to_node(to_node), .edge_ready(edge_ready),
        .edge_value(edge_value), .dist_rd_addr(dist_rd_addr),
        .dist_rd_data(dist_rd_data), .visited_rd_data(visited_rd_data),
        .dist_wr_en(dist_wr_en), .dist_wr_addr(dist_wr_addr),
        .dist_wr_data(dist_wr_data), .prev_wr_data(prev_wr_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Distance/visited table: synchronous read, one cycle latency.
    always @(posedge clock) begin
        dist_rd_data    <= dist_mem[dist_rd_addr];
        visited_rd_data <= vis_mem[dist_rd_addr];
    end

    // EdgeCache: garbage (optionally with ready high) in the cycle after to_node changes,
    // then ready with the true weight once edge_delay cycles have elapsed.
    assign mismatch   = query_enable && ({1'b0, to_node} != last_to);
    assign edge_ready = mismatch ? toggle_mode : (query_enable && cnt >= edge_delay);
    assign edge_value = (!mismatch && query_enable && cnt >= edge_delay) ? row_w[to_node] : 16'hBEEF;

    always @(posedge clock) begin
        if (!query_enable) begin
            last_to <= 9'h1FF;
            cnt     <= 0;
        end else if (mismatch) begin
            last_to <= {1'b0, to_node};
            cnt     <= 1;
        end else if (cnt < 1000) begin
            cnt <= cnt + 1;
        end
    end

    task automatic clear_tables();
        for (int i = 0; i < 256; i++) begin
            row_w[i]    = 16'h0000;
            dist_mem[i] = 16'hFFFF;
            vis_mem[i]  = 1'b0;
        end
    endtask

    task automatic build_expected(input logic [7:0] u, input logic [15:0] du,
                                  input logic [7:0] n, output int count);
        logic [16:0] s;
        exp_q.delete();
        count = 0;
        for (int v = 0; v < int'(n); v++) begin
            s = {1'b0, du} + {1'b0, row_w[v]};
            if (row_w[v] != 16'h0 && v != int'(u) && !vis_mem[v] && du != 16'hFFFF
                && s < {1'b0, dist_mem[v]}) begin
                exp_q.push_back({8'(v), s[15:0], u});
                count++;
            end
        end
    endtask

    task automatic run_row(input logic [7:0] u, input logic [15:0] du, input logic [7:0] n,
                           input bit mid_start, output bit timed_out, output int done_cnt,
                           output bit qe_seen, output int bad_from);
        int cycles;
        obs_q.delete();
        done_cnt  = 0;
        qe_seen   = 1'b0;
        bad_from  = 0;
        timed_out = 1'b1;
        cycles    = 0;
        @(negedge clock);
        current_node = u; current_dist = du; number_of_nodes = n; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        while (timed_out && cycles < 20 * (int'(n) + 2)) begin
            if (dist_wr_en) obs_q.push_back({dist_wr_addr, dist_wr_data, prev_wr_data});
            if (query_enable) qe_seen = 1'b1;
            if (query_enable && from_node !== u) bad_from++;
            if (done) begin done_cnt++; timed_out = 1'b0; end
            if (mid_start && cycles == 4) begin
                start = 1'b1; current_node = ~u; current_dist = 16'h0001; number_of_nodes = 8'd200;
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
            cycles++;
        end
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (done) done_cnt++;
            if (dist_wr_en) obs_q.push_back({dist_wr_addr, dist_wr_data, prev_wr_data});
            if (query_enable) qe_seen = 1'b1;
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0;
        current_node = 8'h0; current_dist = 16'h0; number_of_nodes = 8'h0;
        edge_delay = 1; toggle_mode = 1'b0;
        clear_tables();
        repeat (3) @(negedge clock);
        n_cmp++;
        if ({busy, done, query_enable, dist_wr_en} !== 4'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 0000", {busy, done, query_enable, dist_wr_en});
        end
        n_cmp++;
        if ({relax_count, from_node, to_node, dist_rd_addr, dist_wr_addr, dist_wr_data, prev_wr_data} !== 64'h0) begin
            n_fail++; $display("FAIL reset_data: got %h want 0",
                {relax_count, from_node, to_node, dist_rd_addr, dist_wr_addr, dist_wr_data, prev_wr_data});
        end
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_basic();
        int ec, dc, bf; bit to, qs; wr_t e, o;
        clear_tables();
        row_w[1] = 16'd3; row_w[3] = 16'd10;
        dist_mem[0] = 16'd5; dist_mem[3] = 16'd12;
        build_expected(8'd0, 16'd5, 8'd4, ec);
        run_row(8'd0, 16'd5, 8'd4, 1'b0, to, dc, qs, bf);
        n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL basic_timeout: got %0b want 0", to); end
        n_cmp++; if (dc != 1) begin n_fail++; $display("FAIL basic_done_pulses: got %0d want 1", dc); end
        n_cmp++; if (relax_count !== 8'(ec)) begin n_fail++; $display("FAIL basic_relax_count: got %0d want %0d", relax_count, ec); end
        n_cmp++; if (ec != 1) begin n_fail++; $display("FAIL basic_model_count: got %0d want 1", ec); end
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL basic_nwrites: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin n_fail++; $display("FAIL basic_write: got %h want %h", o, e); end
        end
        n_cmp++; if ({busy, query_enable} !== 2'b00) begin n_fail++; $display("FAIL basic_idle_after: got %b want 00", {busy, query_enable}); end
    endtask

    task automatic test_saturation();
        int ec, dc, bf; bit to, qs;
        clear_tables();
        row_w[1] = 16'h0020;
        build_expected(8'd0, 16'hFFF0, 8'd2, ec);
        run_row(8'd0, 16'hFFF0, 8'd2, 1'b0, to, dc, qs, bf);
        n_cmp++; if (to !== 1'b0 || dc != 1) begin n_fail++; $display("FAIL sat_carry_done: got to=%0b pulses=%0d want 0/1", to, dc); end
        n_cmp++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL sat_carry_writes: got %0d want 0", obs_q.size()); end
        n_cmp++; if (relax_count !== 8'd0) begin n_fail++; $display("FAIL sat_carry_count: got %0d want 0", relax_count); end
        for (int i = 0; i < 4; i++) row_w[i] = 16'(i + 1);
        run_row(8'd0, 16'hFFFF, 8'd4, 1'b0, to, dc, qs, bf);
        n_cmp++; if (to !== 1'b0 || dc != 1) begin n_fail++; $display("FAIL sat_inf_done: got to=%0b pulses=%0d want 0/1", to, dc); end
        n_cmp++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL sat_inf_writes: got %0d want 0", obs_q.size()); end
    endtask

    task automatic test_visited_self();
        int ec, dc, bf; bit to, qs; wr_t e, o;
        clear_tables();
        row_w[0] = 16'd1; vis_mem[0] = 1'b1; dist_mem[0] = 16'd100;
        row_w[1] = 16'd2; dist_mem[1] = 16'd12;
        row_w[2] = 16'd5; dist_mem[2] = 16'd100;
        row_w[3] = 16'd1; dist_mem[3] = 16'd100;
        row_w[4] = 16'd3; dist_mem[4] = 16'd14;
        build_expected(8'd2, 16'd10, 8'd5, ec);
        run_row(8'd2, 16'd10, 8'd5, 1'b0, to, dc, qs, bf);
        n_cmp++; if (to !== 1'b0 || dc != 1) begin n_fail++; $display("FAIL vis_done: got to=%0b pulses=%0d want 0/1", to, dc); end
        n_cmp++; if (relax_count !== 8'd2) begin n_fail++; $display("FAIL vis_relax_count: got %0d want 2", relax_count); end
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL vis_nwrites: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin n_fail++; $display("FAIL vis_write: got %h want %h", o, e); end
        end
    endtask

    task automatic test_delay_toggle();
        int ec, dc, bf; bit to, qs; wr_t e, o;
        clear_tables();
        for (int i = 0; i < 6; i++) begin
            row_w[i]    = 16'($urandom_range(0, 40));
            dist_mem[i] = 16'($urandom_range(10, 80));
            vis_mem[i]  = 1'($urandom_range(0, 3) == 0);
        end
        row_w[2] = 16'd1; dist_mem[2] = 16'hFFFF; vis_mem[2] = 1'b0;
        edge_delay = 7; toggle_mode = 1'b1;
        build_expected(8'd1, 16'd20, 8'd6, ec);
        run_row(8'd1, 16'd20, 8'd6, 1'b0, to, dc, qs, bf);
        edge_delay = 1; toggle_mode = 1'b0;
        n_cmp++; if (to !== 1'b0 || dc != 1) begin n_fail++; $display("FAIL delay_done: got to=%0b pulses=%0d want 0/1", to, dc); end
        n_cmp++; if (bf != 0) begin n_fail++; $display("FAIL delay_from_node: got %0d bad cycles want 0", bf); end
        n_cmp++; if (relax_count !== 8'(ec)) begin n_fail++; $display("FAIL delay_relax_count: got %0d want %0d", relax_count, ec); end
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL delay_nwrites: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin n_fail++; $display("FAIL delay_write: got %h want %h", o, e); end
        end
    endtask

    task automatic test_back_to_back();
        int ec, dc, bf; bit to, qs; wr_t e, o;
        clear_tables();
        for (int i = 0; i < 5; i++) row_w[i] = 16'(2 * i + 1);
        dist_mem[4] = 16'd9;
        build_expected(8'd3, 16'd0, 8'd5, ec);
        run_row(8'd3, 16'd0, 8'd5, 1'b1, to, dc, qs, bf);
        n_cmp++; if (to !== 1'b0 || dc != 1) begin n_fail++; $display("FAIL b2b_done: got to=%0b pulses=%0d want 0/1", to, dc); end
        n_cmp++; if (relax_count !== 8'(ec)) begin n_fail++; $display("FAIL b2b_relax_count: got %0d want %0d", relax_count, ec); end
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_nwrites: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin n_fail++; $display("FAIL b2b_write: got %h want %h", o, e); end
        end
        // Full-size row immediately afterwards exercises the last column without wrap.
        for (int i = 0; i < 256; i++) row_w[i] = 16'd1;
        dist_mem[4] = 16'hFFFF;
        build_expected(8'd7, 16'd1, 8'd255, ec);
        run_row(8'd7, 16'd1, 8'd255, 1'b0, to, dc, qs, bf);
        n_cmp++; if (to !== 1'b0 || dc != 1) begin n_fail++; $display("FAIL big_done: got to=%0b pulses=%0d want 0/1", to, dc); end
        n_cmp++; if (relax_count !== 8'd254) begin n_fail++; $display("FAIL big_relax_count: got %0d want 254", relax_count); end
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL big_nwrites: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            if (o !== e) begin n_cmp++; n_fail++; $display("FAIL big_write: got %h want %h", o, e); end
        end
    endtask

    task automatic test_n_zero();
        int dc, bf; bit to, qs;
        run_row(8'd5, 16'd3, 8'd0, 1'b0, to, dc, qs, bf);
        n_cmp++; if (to !== 1'b0 || dc != 1) begin n_fail++; $display("FAIL nzero_done: got to=%0b pulses=%0d want 0/1", to, dc); end
        n_cmp++; if (qs !== 1'b0) begin n_fail++; $display("FAIL nzero_query_enable: got %0b want 0", qs); end
        n_cmp++; if (relax_count !== 8'd0) begin n_fail++; $display("FAIL nzero_relax_count: got %0d want 0", relax_count); end
        n_cmp++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL nzero_writes: got %0d want 0", obs_q.size()); end
    endtask

    task automatic test_reset_mid();
        int ec, dc, bf, cyc, wr_seen; bit to, qs; wr_t e, o;
        clear_tables();
        row_w[1] = 16'd3; row_w[2] = 16'd4; row_w[3] = 16'd5;
        edge_delay = 7;
        @(negedge clock);
        current_node = 8'd0; current_dist = 16'd5; number_of_nodes = 8'd4; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        cyc = 0;
        while (to_node !== 8'd2 && cyc < 100) begin @(negedge clock); cyc++; end
        n_cmp++; if (to_node !== 8'd2) begin n_fail++; $display("FAIL midrst_reach_v2: got %0d want 2", to_node); end
        repeat (3) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, query_enable, dist_wr_en} !== 4'b0) begin
            n_fail++; $display("FAIL midrst_ctrl: got %b want 0000", {busy, done, query_enable, dist_wr_en});
        end
        n_cmp++;
        if ({relax_count, from_node, to_node, dist_rd_addr, dist_wr_addr, dist_wr_data, prev_wr_data} !== 64'h0) begin
            n_fail++; $display("FAIL midrst_data: got %h want 0",
                {relax_count, from_node, to_node, dist_rd_addr, dist_wr_addr, dist_wr_data, prev_wr_data});
        end
        wr_seen = 0;
        for (int i = 0; i < 3; i++) begin @(negedge clock); if (dist_wr_en) wr_seen++; end
        n_cmp++; if (wr_seen != 0) begin n_fail++; $display("FAIL midrst_no_write: got %0d want 0", wr_seen); end
        reset = 1'b1;
        edge_delay = 1;
        build_expected(8'd0, 16'd5, 8'd4, ec);
        run_row(8'd0, 16'd5, 8'd4, 1'b0, to, dc, qs, bf);
        n_cmp++; if (to !== 1'b0 || dc != 1) begin n_fail++; $display("FAIL midrst_rerun_done: got to=%0b pulses=%0d want 0/1", to, dc); end
        n_cmp++; if (relax_count !== 8'd3) begin n_fail++; $display("FAIL midrst_rerun_count: got %0d want 3", relax_count); end
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL midrst_nwrites: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin n_fail++; $display("FAIL midrst_write: got %h want %h", o, e); end
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_basic();
        test_saturation();
        test_visited_self();
        test_delay_toggle();
        test_back_to_back();
        test_n_zero();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
